// File: rtl/wdm_waveguide.sv
// -----------------------------------------------------------------------------
// wdm_waveguide
//
// Bidirectional multi-wavelength waveguide model for the ONoC simulator. Each of
// N_CH wavelength channels carries an independent packet stream left-to-right
// (LR) and right-to-left (RL) through a fixed DELAY-stage delay line. One
// instance models one physical link between two optical router ports.
//
// Parameters
//   DELAY      delay-line depth in cycles (2..64)
//   N_CH       number of wavelength channels (1..32)
//   LOOKAHEAD  cycles before delivery that arrive_soon_* asserts (1..DELAY-1)
//   CNT_W      width of the saturating statistics counters
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   ch_en               per-channel injection enable (both directions)
//   data_in_lr/_rl      injected packet per channel
//   valid_in_lr/_rl     injection valid per channel
//   data_out_right/left delivered packet per channel (LR / RL)
//   valid_out_right/left delivery valid per channel
//   arrive_soon_right/left  a delivery follows in LOOKAHEAD cycles
//   occ_lr/_rl          valid stages in flight per channel
//   delivered_lr/_rl    saturating delivery counts per direction
//   dropped             saturating count of injections refused by ch_en
//
// Build option
//   WDM_WAVEGUIDE_TRACE_EN  when defined, prints a per-cycle trace of every
//                           delay line and one line per delivery. Logic is
//                           identical either way.
// -----------------------------------------------------------------------------

package wdm_waveguide_pkg;

  // Optical packet as carried on one wavelength.
  typedef struct packed {
    logic [15:0] timestamp;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [7:0]  payload;
  } packet_t;

endpackage

module wdm_waveguide
  import wdm_waveguide_pkg::*;
#(
  parameter int DELAY     = 4,
  parameter int N_CH      = 4,
  parameter int LOOKAHEAD = 1,
  parameter int CNT_W     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_CH-1:0]                       ch_en,
  input  packet_t [N_CH-1:0]                    data_in_lr,
  input  logic [N_CH-1:0]                       valid_in_lr,
  input  packet_t [N_CH-1:0]                    data_in_rl,
  input  logic [N_CH-1:0]                       valid_in_rl,
  output packet_t [N_CH-1:0]                    data_out_right,
  output logic [N_CH-1:0]                       valid_out_right,
  output packet_t [N_CH-1:0]                    data_out_left,
  output logic [N_CH-1:0]                       valid_out_left,
  output logic [N_CH-1:0]                       arrive_soon_right,
  output logic [N_CH-1:0]                       arrive_soon_left,
  output logic [N_CH-1:0][$clog2(DELAY+1)-1:0]  occ_lr,
  output logic [N_CH-1:0][$clog2(DELAY+1)-1:0]  occ_rl,
  output logic [CNT_W-1:0]                      delivered_lr,
  output logic [CNT_W-1:0]                      delivered_rl,
  output logic [CNT_W-1:0]                      dropped
);

  localparam int OCC_W = $clog2(DELAY + 1);
  // Per-cycle increments are summed at this width so a sum near the ceiling
  // cannot wrap before it is clamped.
  localparam int SUM_W = CNT_W + $clog2(2 * N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Elaboration-time parameter guards.
  if (DELAY < 2 || DELAY > 64) begin : g_bad_delay
    $error("wdm_waveguide: DELAY must be in 2..64");
  end
  if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
    $error("wdm_waveguide: N_CH must be in 1..32");
  end
  if (LOOKAHEAD < 1 || LOOKAHEAD > DELAY - 1) begin : g_bad_la
    $error("wdm_waveguide: LOOKAHEAD must be in 1..DELAY-1");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [OCC_W-1:0] count_stages(input logic [DELAY-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int i = 0; i < DELAY; i++) n = n + OCC_W'(v[i]);
    return n;
  endfunction

  function automatic logic [SUM_W-1:0] count_ch(input logic [N_CH-1:0] v);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) n = n + SUM_W'(v[i]);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + b;
    if (s > SUM_W'(CNT_MAX)) return CNT_MAX;
    return s[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Delay-line state: bit/element 0 is the injection stage, DELAY-1 the output.
  // ---------------------------------------------------------------------------
  logic    [DELAY-1:0] vld_lr_q [N_CH];
  logic    [DELAY-1:0] vld_rl_q [N_CH];
  packet_t [DELAY-1:0] dat_lr_q [N_CH];
  packet_t [DELAY-1:0] dat_rl_q [N_CH];

  logic    [DELAY-1:0] vld_lr_d [N_CH];
  logic    [DELAY-1:0] vld_rl_d [N_CH];
  packet_t [DELAY-1:0] dat_lr_d [N_CH];
  packet_t [DELAY-1:0] dat_rl_d [N_CH];

  logic [N_CH-1:0] acc_lr, acc_rl;   // accepted injections
  logic [N_CH-1:0] ref_lr, ref_rl;   // injections refused by ch_en

  // ch_en gates only what enters stage 0; stages already loaded keep moving.
  assign acc_lr = valid_in_lr & ch_en;
  assign acc_rl = valid_in_rl & ch_en;
  assign ref_lr = valid_in_lr & ~ch_en;
  assign ref_rl = valid_in_rl & ~ch_en;

  // NOTE: every always_comb output gets a default before any conditional or
  // loop assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    for (int ch = 0; ch < N_CH; ch++) begin
      vld_lr_d[ch] = '0;
      vld_rl_d[ch] = '0;
      dat_lr_d[ch] = '0;
      dat_rl_d[ch] = '0;

      vld_lr_d[ch] = {vld_lr_q[ch][DELAY-2:0], acc_lr[ch]};
      vld_rl_d[ch] = {vld_rl_q[ch][DELAY-2:0], acc_rl[ch]};
      // A refused or idle stage 0 carries all-zero data, not stale input.
      dat_lr_d[ch] = {dat_lr_q[ch][DELAY-2:0], acc_lr[ch] ? data_in_lr[ch] : packet_t'('0)};
      dat_rl_d[ch] = {dat_rl_q[ch][DELAY-2:0], acc_rl[ch] ? data_in_rl[ch] : packet_t'('0)};
    end
  end

  // NOTE: the delay-line storage is reset along with the control bits. A reset
  // must discard in-flight packets and every output must read 0 while rst_n is
  // low, and the data outputs come straight from the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        vld_lr_q[ch] <= '0;
        vld_rl_q[ch] <= '0;
        dat_lr_q[ch] <= '0;
        dat_rl_q[ch] <= '0;
        occ_lr[ch]   <= '0;
        occ_rl[ch]   <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      for (int ch = 0; ch < N_CH; ch++) begin
        vld_lr_q[ch] <= vld_lr_d[ch];
        vld_rl_q[ch] <= vld_rl_d[ch];
        dat_lr_q[ch] <= dat_lr_d[ch];
        dat_rl_q[ch] <= dat_rl_d[ch];
        // Occupancy is the popcount of the post-edge valid bits, not a tracker.
        occ_lr[ch]   <= count_stages(vld_lr_d[ch]);
        occ_rl[ch]   <= count_stages(vld_rl_d[ch]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs taken directly from the delay-line registers.
  // ---------------------------------------------------------------------------
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_out
    assign valid_out_right[ch]   = vld_lr_q[ch][DELAY-1];
    assign valid_out_left[ch]    = vld_rl_q[ch][DELAY-1];
    assign data_out_right[ch]    = dat_lr_q[ch][DELAY-1];
    assign data_out_left[ch]     = dat_rl_q[ch][DELAY-1];
    assign arrive_soon_right[ch] = vld_lr_q[ch][DELAY-1-LOOKAHEAD];
    assign arrive_soon_left[ch]  = vld_rl_q[ch][DELAY-1-LOOKAHEAD];
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics. Deliveries are counted on the edge after they are
  // presented on valid_out_*; refusals on the edge that samples them.
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] inc_del_lr, inc_del_rl, inc_drop;

  assign inc_del_lr = count_ch(valid_out_right);
  assign inc_del_rl = count_ch(valid_out_left);
  assign inc_drop   = count_ch(ref_lr) + count_ch(ref_rl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delivered_lr <= '0;
      delivered_rl <= '0;
      dropped      <= '0;
    end else begin
      delivered_lr <= sat_add(delivered_lr, inc_del_lr);
      delivered_rl <= sat_add(delivered_rl, inc_del_rl);
      dropped      <= sat_add(dropped, inc_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Optional simulation trace.
  // ---------------------------------------------------------------------------
`ifdef WDM_WAVEGUIDE_TRACE_EN
  always @(posedge clk) begin
    if (rst_n) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        $write("t=%0t ch%0d LR", $time, ch);
        for (int s = 0; s < DELAY; s++)
          $write(" [%0d:%0b:%0d]", s, vld_lr_q[ch][s], dat_lr_q[ch][s].timestamp);
        $write(" RL");
        for (int s = 0; s < DELAY; s++)
          $write(" [%0d:%0b:%0d]", s, vld_rl_q[ch][s], dat_rl_q[ch][s].timestamp);
        $write("\n");
        if (valid_out_right[ch])
          $display("deliver ch=%0d dir=LR ts=%0d time=%0t",
                   ch, data_out_right[ch].timestamp, $time);
        if (valid_out_left[ch])
          $display("deliver ch=%0d dir=RL ts=%0d time=%0t",
                   ch, data_out_left[ch].timestamp, $time);
      end
    end
  end
`else
  // Trace disabled: the model produces no simulation output.
`endif

endmodule

// File: tb/tb_wdm_waveguide.sv
// -----------------------------------------------------------------------------
// tb_wdm_waveguide
//
// Directed bench for wdm_waveguide. dut_a uses the default configuration;
// dut_b shares its stimulus but uses CNT_W=4 and LOOKAHEAD=3 to exercise
// counter saturation and the maximum lookahead. Expected deliveries are pushed
// to a scoreboard queue at injection and popped when due.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_wdm_waveguide;
  import wdm_waveguide_pkg::*;

  localparam int DELAY = 4;
  localparam int N_CH  = 4;
  localparam int LA_A  = 1;
  localparam int LA_B  = 3;
  localparam int CW_A  = 16;
  localparam int CW_B  = 4;
  localparam int OW    = $clog2(DELAY + 1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N_CH-1:0]  ch_en;
  packet_t [N_CH-1:0] data_in_lr, data_in_rl;
  logic [N_CH-1:0]  valid_in_lr, valid_in_rl;

  packet_t [N_CH-1:0] dor_a, dol_a, dor_b, dol_b;
  logic [N_CH-1:0]  vor_a, vol_a, vor_b, vol_b;
  logic [N_CH-1:0]  asr_a, asl_a, asr_b, asl_b;
  logic [N_CH-1:0][OW-1:0] occ_lr_a, occ_rl_a, occ_lr_b, occ_rl_b;
  logic [CW_A-1:0]  del_lr_a, del_rl_a, drop_a;
  logic [CW_B-1:0]  del_lr_b, del_rl_b, drop_b;

  wdm_waveguide #(.DELAY(DELAY), .N_CH(N_CH), .LOOKAHEAD(LA_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
    .data_in_lr(data_in_lr), .valid_in_lr(valid_in_lr),
    .data_in_rl(data_in_rl), .valid_in_rl(valid_in_rl),
    .data_out_right(dor_a), .valid_out_right(vor_a),
    .data_out_left(dol_a), .valid_out_left(vol_a),
    .arrive_soon_right(asr_a), .arrive_soon_left(asl_a),
    .occ_lr(occ_lr_a), .occ_rl(occ_rl_a),
    .delivered_lr(del_lr_a), .delivered_rl(del_rl_a), .dropped(drop_a)
  );

  wdm_waveguide #(.DELAY(DELAY), .N_CH(N_CH), .LOOKAHEAD(LA_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en),
    .data_in_lr(data_in_lr), .valid_in_lr(valid_in_lr),
    .data_in_rl(data_in_rl), .valid_in_rl(valid_in_rl),
    .data_out_right(dor_b), .valid_out_right(vor_b),
    .data_out_left(dol_b), .valid_out_left(vol_b),
    .arrive_soon_right(asr_b), .arrive_soon_left(asl_b),
    .occ_lr(occ_lr_b), .occ_rl(occ_rl_b),
    .delivered_lr(del_lr_b), .delivered_rl(del_rl_b), .dropped(drop_b)
  );

  // Scoreboard entry: one expected delivery.
  typedef struct {
    bit      dir;   // 0 = LR (right output), 1 = RL (left output)
    int      ch;
    packet_t pkt;
    int      due;   // tick count at which valid_out shows it
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  int   del_lr_m = 0, del_rl_m = 0, drop_m = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Compare every cycle-level output against the scoreboard, then retire
  // the entries due now.
  task automatic monitor();
    logic [N_CH-1:0] ev_r, ev_l, ea_r, ea_l, eb_r, eb_l;
    logic [N_CH-1:0][OW-1:0] eo_lr, eo_rl;
    exp_t e;
    packet_t obs_a, obs_b;
    ev_r = '0; ev_l = '0; ea_r = '0; ea_l = '0; eb_r = '0; eb_l = '0;
    eo_lr = '0; eo_rl = '0;
    foreach (sb[i]) begin
      if (sb[i].dir == 1'b0) begin
        eo_lr[sb[i].ch] = eo_lr[sb[i].ch] + OW'(1);
        if (sb[i].due == cycle)        ev_r[sb[i].ch] = 1'b1;
        if (sb[i].due == cycle + LA_A) ea_r[sb[i].ch] = 1'b1;
        if (sb[i].due == cycle + LA_B) eb_r[sb[i].ch] = 1'b1;
      end else begin
        eo_rl[sb[i].ch] = eo_rl[sb[i].ch] + OW'(1);
        if (sb[i].due == cycle)        ev_l[sb[i].ch] = 1'b1;
        if (sb[i].due == cycle + LA_A) ea_l[sb[i].ch] = 1'b1;
        if (sb[i].due == cycle + LA_B) eb_l[sb[i].ch] = 1'b1;
      end
    end
    check("valid_out_right", 64'(vor_a), 64'(ev_r));
    check("valid_out_left",  64'(vol_a), 64'(ev_l));
    check("valid_out_right_b", 64'(vor_b), 64'(ev_r));
    check("valid_out_left_b",  64'(vol_b), 64'(ev_l));
    check("arrive_soon_right", 64'(asr_a), 64'(ea_r));
    check("arrive_soon_left",  64'(asl_a), 64'(ea_l));
    check("arrive_soon_right_la3", 64'(asr_b), 64'(eb_r));
    check("arrive_soon_left_la3",  64'(asl_b), 64'(eb_l));
    check("occ_lr", 64'(occ_lr_a), 64'(eo_lr));
    check("occ_rl", 64'(occ_rl_a), 64'(eo_rl));
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ((d == 0) ? ev_r[ch] : ev_l[ch]) begin
          e = sb.pop_front();
          obs_a = (d == 0) ? dor_a[ch] : dol_a[ch];
          obs_b = (d == 0) ? dor_b[ch] : dol_b[ch];
          check(d == 0 ? "data_out_right" : "data_out_left", 64'(obs_a), 64'(e.pkt));
          check(d == 0 ? "data_out_right_b" : "data_out_left_b", 64'(obs_b), 64'(e.pkt));
          if (d == 0) del_lr_m++; else del_rl_m++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    valid_in_lr = '0;
    valid_in_rl = '0;
    data_in_lr  = '0;
    data_in_rl  = '0;
    monitor();
  endtask

  // Drive one cycle of injections; accepted ones go to the scoreboard.
  task automatic inject(input logic [N_CH-1:0] lr, input logic [N_CH-1:0] rl,
                        input logic [15:0] ts);
    packet_t p;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ((d == 0) ? lr[ch] : rl[ch]) begin
          p.timestamp = ts;
          p.src       = 4'(ch);
          p.dst       = 4'(d);
          p.payload   = 8'($urandom_range(255));
          if (d == 0) begin data_in_lr[ch] = p; valid_in_lr[ch] = 1'b1; end
          else        begin data_in_rl[ch] = p; valid_in_rl[ch] = 1'b1; end
          if (ch_en[ch]) begin
            e.dir = (d == 1); e.ch = ch; e.pkt = p; e.due = cycle + DELAY;
            sb.push_back(e);
          end else begin
            drop_m++;
          end
        end
      end
    end
    tick();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_delivered_lr"}, 64'(del_lr_a), 64'(sat(del_lr_m, CW_A)));
    check({tag, "_delivered_rl"}, 64'(del_rl_a), 64'(sat(del_rl_m, CW_A)));
    check({tag, "_dropped"},      64'(drop_a),   64'(sat(drop_m, CW_A)));
    check({tag, "_delivered_lr_w4"}, 64'(del_lr_b), 64'(sat(del_lr_m, CW_B)));
    check({tag, "_delivered_rl_w4"}, 64'(del_rl_b), 64'(sat(del_rl_m, CW_B)));
    check({tag, "_dropped_w4"},      64'(drop_b),   64'(sat(drop_m, CW_B)));
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, hold, release
  // mid-cycle. In-flight packets are lost from the model too.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    sb.delete();
    del_lr_m = 0; del_rl_m = 0; drop_m = 0;
    #1;
    check("rst_valid_out", 64'({vor_a, vol_a, vor_b, vol_b}), 64'(0));
    check("rst_arrive",    64'({asr_a, asl_a, asr_b, asl_b}), 64'(0));
    check("rst_occ",       64'({occ_lr_a, occ_rl_a}), 64'(0));
    check("rst_data_out",  64'(dor_a) | 64'(dol_a), 64'(0));
    check_counters("rst");
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    ch_en       = '1;
    valid_in_lr = '0;
    valid_in_rl = '0;
    data_in_lr  = '0;
    data_in_rl  = '0;
    tick();
    check_counters("reset_state");
    tick();
    #2;
    rst_n = 1'b1;
    tick();

    // Single packet, ts 7 on ch2 LR.
    inject(4'b0100, 4'b0000, 16'd7);
    repeat (6) tick();
    check_counters("single");
    check("single_delivered_lr_is_1", 64'(del_lr_a), 64'(1));

    // Full-rate burst on all channels, both directions.
    do_reset();
    for (int i = 0; i < 10; i++) inject('1, '1, 16'(100 + i));
    repeat (6) tick();
    check_counters("burst");
    check("burst_delivered_lr_40", 64'(del_lr_a), 64'(40));
    check("burst_delivered_w4_sat", 64'(del_rl_b), 64'(15));

    // Channel 2 disabled: its injection is refused and counted.
    ch_en = 4'b1011;
    inject('1, 4'b0000, 16'd50);
    repeat (6) tick();
    ch_en = '1;
    check_counters("ch_en");

    // ch_en drops while a ch0 packet is at stage 1: it still delivers.
    inject(4'b0001, 4'b0000, 16'd60);
    tick();
    ch_en[0] = 1'b0;
    repeat (5) tick();
    ch_en = '1;
    check_counters("in_flight");

    // Packets at stages 1 and 3 on ch1, then asynchronous reset mid-cycle.
    inject(4'b0010, 4'b0010, 16'd70);
    tick();
    inject(4'b0010, 4'b0000, 16'd71);
    tick();
    do_reset();
    repeat (8) tick();
    check_counters("post_reset");

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
